// File: rtl/fp16_mul_round.sv
// fp16_mul_round: normalize, round-to-nearest-even and pack an FP16 product over a 2-stage valid/ready pipeline
module fp16_mul_round #(
  parameter int N = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sign,
  input  logic [5:0]     in_exp_sum,
  input  logic [2*N-1:0] in_prod,
  input  logic           in_zero,
  input  logic           in_inf,
  input  logic           in_nan,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    out_result,
  output logic [2:0]     out_flags
);
  logic       r_s1_valid, r_sign, r_guard, r_sticky, r_zero, r_inf, r_nan;
  logic [9:0] r_mant;
  logic [7:0] r_exp;
  logic       w_s1_en, w_s2_en, w_hi, w_guard, w_sticky, w_up, w_ovf, w_unf, w_unused;
  logic [9:0] w_mant;
  logic [7:0] w_exp, w_rexp;
  logic [10:0] w_msum;
  logic [15:0] w_res;
  logic [2:0]  w_flg;
  assign w_unused = ^in_prod[2*N-1:22];
  assign w_s2_en  = !out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;
  assign w_hi     = in_prod[21];
  assign w_mant   = w_hi ? in_prod[20:11] : in_prod[19:10];
  assign w_guard  = w_hi ? in_prod[10] : in_prod[9];
  assign w_sticky = w_hi ? |in_prod[9:0] : |in_prod[8:0];
  assign w_exp    = {2'b00, in_exp_sum} - (w_hi ? 8'd14 : 8'd15);
  // A carry out of the mantissa leaves w_msum[9:0] at zero, which is the renormalized mantissa.
  assign w_up   = r_guard && (r_sticky || r_mant[0]);
  assign w_msum = {1'b0, r_mant} + {10'd0, w_up};
  assign w_rexp = r_exp + {7'd0, w_msum[10]};
  assign w_ovf  = $signed(w_rexp) >= 8'sd31;
  assign w_unf  = $signed(w_rexp) <= 8'sd0;
  always_comb begin
    w_res = (r_nan || (r_inf && r_zero)) ? 16'h7E00 :
            r_inf  ? {r_sign, 15'h7C00} :
            r_zero ? {r_sign, 15'h0000} :
            w_ovf  ? {r_sign, 15'h7C00} :
            w_unf  ? {r_sign, 15'h0000} :
                     {r_sign, w_rexp[4:0], w_msum[9:0]};
    w_flg = (r_nan || r_inf || r_zero) ? 3'b000 :
            w_ovf ? 3'b101 :
            w_unf ? 3'b011 :
                    {2'b00, r_guard || r_sticky};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_flags  <= 3'b000;
    end else begin
      if (w_s1_en) r_s1_valid <= in_valid;
      if (w_s2_en) out_valid <= r_s1_valid;
      if (w_s2_en && r_s1_valid) begin
        out_result <= w_res;
        out_flags  <= w_flg;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (w_s1_en && in_valid) begin
      r_sign   <= in_sign;
      r_mant   <= w_mant;
      r_guard  <= w_guard;
      r_sticky <= w_sticky;
      r_exp    <= w_exp;
      r_zero   <= in_zero;
      r_inf    <= in_inf;
      r_nan    <= in_nan;
    end
  end
endmodule

// File: tb/tb_fp16_mul_round.sv
// tb_fp16_mul_round: directed and randomized checks of fp16_mul_round against an arithmetic reference model
module tb_fp16_mul_round;
  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
  logic        out_valid, out_ready;
  logic [5:0]  in_exp_sum;
  logic [31:0] in_prod;
  logic [15:0] out_result;
  logic [2:0]  out_flags;
  int n_vec = 0, n_err = 0, n_out = 0, acc = 0;
  logic [18:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out;
  always #5 clock = ~clock;
  fp16_mul_round #(.N(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp_sum(in_exp_sum), .in_prod(in_prod),
    .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  // Reference: exact integer rounding of the significand product, then range classification.
  function automatic logic [18:0] model(input logic s, input logic [5:0] es, input logic [31:0] p32,
                                        input logic z, input logic i, input logic n);
    longint p, keep, rem, half;
    int sh, e;
    if (n || (i && z)) return {16'h7E00, 3'b000};
    if (i) return {s, 15'h7C00, 3'b000};
    if (z) return {s, 15'h0000, 3'b000};
    p = longint'(p32 & 32'h003F_FFFF);
    sh = (p >= 64'd2097152) ? 11 : 10;
    e = int'(es) - ((sh == 11) ? 14 : 15);
    keep = p >> sh;
    rem = p - (keep << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep == 2048) begin
      keep = 1024;
      e++;
    end
    if (e >= 31) return {s, 15'h7C00, 3'b101};
    if (e <= 0) return {s, 15'h0000, 3'b011};
    return {s, e[4:0], keep[9:0], 2'b00, rem != 0};
  endfunction
  task automatic rand_beat(input bit normal_only);
    int ma, mb, k;
    ma = int'($urandom_range(1024, 2047));
    mb = int'($urandom_range(1024, 2047));
    in_prod = ($urandom() & 32'hFFC0_0000) | 32'(ma * mb);
    in_exp_sum = 6'($urandom_range(2, 60));
    in_sign = 1'($urandom_range(0, 1));
    k = normal_only ? 19 : int'($urandom_range(0, 19));
    in_zero = (k == 0 || k == 3);
    in_inf  = (k == 1 || k == 3 || k == 4);
    in_nan  = (k == 2 || k == 4);
  endtask
  task automatic step();
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'({out_result, out_flags}), 32'(prev_out));
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else check("result", 32'({out_result, out_flags}), 32'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) begin
      acc++;
      exp_q.push_back(model(in_sign, in_exp_sum, in_prod, in_zero, in_inf, in_nan));
    end
    prev_stall = out_valid && !out_ready;
    prev_out = {out_result, out_flags};
    @(negedge clock);
  endtask
  task automatic dir(input string tag, input logic s, input logic [5:0] es, input logic [31:0] p,
                     input logic z, input logic i, input logic n, input logic [15:0] r, input logic [2:0] f);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_sign = s;
    in_exp_sum = es;
    in_prod = p;
    in_zero = z;
    in_inf = i;
    in_nan = n;
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    #1 check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clock);
    #1 check({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check(tag, 32'({out_result, out_flags}), 32'({r, f}));
    @(negedge clock);
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rand_beat(1'b1);
    repeat (2) @(negedge clock);
    #1 check("rst_state", 32'({out_valid, out_result, out_flags}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    #1 check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    dir("one",      1'b0, 6'd30, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b000);
    dir("norm",     1'b0, 6'd30, 32'h0024_0000, 1'b0, 1'b0, 1'b0, 16'h4080, 3'b000);
    dir("tie_even", 1'b0, 6'd30, 32'h0018_0600, 1'b0, 1'b0, 1'b0, 16'h3E02, 3'b001);
    dir("sticky",   1'b0, 6'd30, 32'h0010_0801, 1'b0, 1'b0, 1'b0, 16'h3C02, 3'b001);
    dir("carry",    1'b0, 6'd30, 32'h001F_FE00, 1'b0, 1'b0, 1'b0, 16'h4000, 3'b001);
    dir("max_norm", 1'b0, 6'd45, 32'h001F_FC00, 1'b0, 1'b0, 1'b0, 16'h7BFF, 3'b000);
    dir("carry_ov", 1'b0, 6'd45, 32'h001F_FE00, 1'b0, 1'b0, 1'b0, 16'h7C00, 3'b101);
    dir("overflow", 1'b1, 6'd46, 32'h001F_FC00, 1'b0, 1'b0, 1'b0, 16'hFC00, 3'b101);
    dir("min_norm", 1'b0, 6'd16, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 16'h0400, 3'b000);
    dir("exp_zero", 1'b1, 6'd15, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 16'h8000, 3'b011);
    dir("underflw", 1'b0, 6'd10, 32'h0010_0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b011);
    dir("hi_ignore",1'b0, 6'd30, 32'hFFD0_0000, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b000);
    dir("inf_zero", 1'b0, 6'd30, 32'h0010_0000, 1'b1, 1'b1, 1'b0, 16'h7E00, 3'b000);
    dir("inf_neg",  1'b1, 6'd30, 32'h0010_0000, 1'b0, 1'b1, 1'b0, 16'hFC00, 3'b000);
    dir("zero_neg", 1'b1, 6'd30, 32'h0010_0000, 1'b1, 1'b0, 1'b0, 16'h8000, 3'b000);
    dir("nan_inf",  1'b1, 6'd30, 32'h0010_0000, 1'b0, 1'b1, 1'b1, 16'h7E00, 3'b000);
    // Backpressure: four beats offered while the consumer stalls.
    exp_q.delete();
    prev_stall = 1'b0;
    acc = 0;
    n_out = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) rand_beat(1'b1);
      step();
    end
    check("bp_accepts", 32'(acc), 32'd2);
    #1 check("bp_stall", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (acc < 4 || exp_q.size() != 0); c++) begin
      in_valid = (acc < 4);
      if (acc < 4) rand_beat(1'b1);
      step();
    end
    in_valid = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_count", 32'(n_out), 32'd4);
    // Reset with two beats in flight discards them.
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      rand_beat(1'b1);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    #1 check("rst_flush", 32'({out_valid, out_result, out_flags}), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    @(negedge clock);
    repeat (6) step();
    check("rst_no_ghost", 32'(n_out), 32'd0);
    // Randomized traffic with random stalls on both sides.
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_beat(1'b0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
